// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared imm_sel codes, NOP word and field bundle for the RV32I encoder
package instr_encoder_pkg;

    // Immediate-format select codes, identical to the immediate generator's
    localparam logic [2:0] IMM_R  = 3'b001;
    localparam logic [2:0] IMM_I  = 3'b010;
    localparam logic [2:0] IMM_IL = 3'b011;
    localparam logic [2:0] IMM_S  = 3'b100;
    localparam logic [2:0] IMM_B  = 3'b101;

    // addi x0,x0,0 emitted in place of a word with an illegal format
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  imm_sel;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm32;
    } enc_fields_t;

    // True when v is a sign-extended 12-bit value
    function automatic logic fits_12(input logic [31:0] v);
        return (v[31:11] == '0) || (v[31:11] == '1);
    endfunction

    // True when v is a sign-extended 13-bit value
    function automatic logic fits_13(input logic [31:0] v);
        return (v[31:12] == '0) || (v[31:12] == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packing of decoded fields into an RV32I word with range check
module instr_pack
    import instr_encoder_pkg::*;
(
    input  enc_fields_t  fields,
    output logic [31:0]  instr,
    output logic         imm_err,
    output logic         sel_err
);

    // Select the bit layout for the format and flag immediates that do not fit it
    always_comb begin
        instr   = NOP_INSTR;
        imm_err = 1'b0;
        sel_err = 1'b0;
        unique case (fields.imm_sel)
            IMM_R: begin
                instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                         fields.rd, fields.opcode};
            end
            IMM_I, IMM_IL: begin
                instr   = {fields.imm32[11:0], fields.rs1, fields.funct3,
                           fields.rd, fields.opcode};
                imm_err = !fits_12(fields.imm32);
            end
            IMM_S: begin
                instr   = {fields.imm32[11:5], fields.rs2, fields.rs1, fields.funct3,
                           fields.imm32[4:0], fields.opcode};
                imm_err = !fits_12(fields.imm32);
            end
            IMM_B: begin
                // Branch offsets are even; a set bit 0 cannot be encoded
                instr   = {fields.imm32[12], fields.imm32[10:5], fields.rs2, fields.rs1,
                           fields.funct3, fields.imm32[4:1], fields.imm32[11], fields.opcode};
                imm_err = !fits_13(fields.imm32) || fields.imm32[0];
            end
            default: begin
                instr   = NOP_INSTR;
                sel_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage RV32I instruction encoder streaming words with byte addresses
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          imm_sel,
    input  logic [6:0]          opcode,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [31:0]         imm32,
    input  logic                addr_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         instr,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                imm_err,
    output logic                sel_err,
    output logic [ERRCNT_W-1:0] err_count
);

    enc_fields_t          in_fields;
    enc_fields_t          s1_fields_q, s1_fields_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          instr_q, instr_d;
    logic                 imm_err_q, imm_err_d;
    logic                 sel_err_q, sel_err_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [ERRCNT_W-1:0]  err_count_q, err_count_d;

    logic                 s1_ready;
    logic                 s2_ready;
    logic                 out_hs;
    logic [31:0]          pk_instr;
    logic                 pk_imm_err;
    logic                 pk_sel_err;

    assign in_fields = '{imm_sel: imm_sel, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                         funct3: funct3, funct7: funct7, imm32: imm32};

    instr_pack u_pack (
        .fields  (s1_fields_q),
        .instr   (pk_instr),
        .imm_err (pk_imm_err),
        .sel_err (pk_sel_err)
    );

    // Ready chain: each stage frees up when its content moves on this cycle
    always_comb begin
        s2_ready = !out_valid_q || out_ready;
        s1_ready = !s1_valid_q || s2_ready;
        out_hs   = out_valid_q && out_ready;
    end

    // Next-state for both stages, the address counter and the error counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        imm_err_d   = imm_err_q;
        sel_err_d   = sel_err_q;
        wr_addr_d   = wr_addr_q;
        err_count_d = err_count_q;

        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_fields_d = in_fields;
            end
        end

        // S2 only reloads when it is empty or its word leaves; otherwise outputs hold
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d   = pk_instr;
                imm_err_d = pk_imm_err;
                sel_err_d = pk_sel_err;
            end
        end

        // A clear wins over the advance; the word leaving now keeps its old address
        if (addr_clr) begin
            wr_addr_d = BASE_ADDR;
        end else if (out_hs) begin
            wr_addr_d = wr_addr_q + ADDR_W'(4);
        end

        if (out_hs && (imm_err_q || sel_err_q) && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    // Pipeline and counter registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            imm_err_q   <= 1'b0;
            sel_err_q   <= 1'b0;
            wr_addr_q   <= BASE_ADDR;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fields_q <= s1_fields_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            imm_err_q   <= imm_err_d;
            sel_err_q   <= sel_err_d;
            wr_addr_q   <= wr_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign imm_err   = imm_err_q;
    assign sel_err   = sel_err_q;
    assign wr_addr   = wr_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - table-driven and scoreboarded bench for instr_encoder
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int NV = 17;

    typedef struct {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_ie;
        logic        exp_se;
    } vec_t;

    typedef struct {
        vec_t v;
        logic rnd;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_sel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm32;
    logic        addr_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] wr_addr;
    logic        imm_err;
    logic        sel_err;
    logic [7:0]  err_count;

    int          checks = 0;
    int          failures = 0;
    sb_t         sb_q[$];
    sb_t         mon_e;
    logic [31:0] exp_addr = BASE;
    logic [7:0]  exp_errcnt = 8'd0;
    logic        rand_ready = 1'b0;
    vec_t        tbl[NV];
    vec_t        rv;
    logic [31:0] held_instr;
    int          n_err;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .ERRCNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_sel   (imm_sel),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm32     (imm32),
        .addr_clr  (addr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .wr_addr   (wr_addr),
        .imm_err   (imm_err),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    always #5 clk = !clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd_v,
                                input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] ei,
                                input logic ie, input logic se);
        vec_t v;
        v.sel = sel; v.op = op; v.rd = rd_v; v.rs1 = rs1_v; v.rs2 = rs2_v; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.exp_instr = ei; v.exp_ie = ie; v.exp_se = se;
        return v;
    endfunction

    // Reference immediate generator: recovers the immediate from an encoded word
    function automatic logic [31:0] immgen(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            3'b100:  return {{20{i[31]}}, i[31:25], i[11:7]};
            3'b101:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    // Present a bundle and hold it until accepted, logging the expectation on acceptance
    task automatic drive(input vec_t v, input logic rnd);
        sb_t e;
        bit  ok = 0;
        imm_sel = v.sel; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm32 = v.imm; in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.v = v; e.rnd = rnd;
                sb_q.push_back(e);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit ok = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb_q.size());
        end
        #1;
    endtask

    // Randomised sink backpressure for the round-trip phase
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard: compare each word leaving the encoder against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_word actual=0x%08h required=none", instr);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("wr_addr", wr_addr, exp_addr);
                    chk("err_count", {24'd0, err_count}, {24'd0, exp_errcnt});
                    chk("imm_err", {31'd0, imm_err}, {31'd0, (mon_e.rnd ? 1'b0 : mon_e.v.exp_ie)});
                    chk("sel_err", {31'd0, sel_err}, {31'd0, (mon_e.rnd ? 1'b0 : mon_e.v.exp_se)});
                    if (!mon_e.rnd) begin
                        chk("instr", instr, mon_e.v.exp_instr);
                    end else begin
                        chk("rt_opcode", {25'd0, instr[6:0]}, {25'd0, mon_e.v.op});
                        if (mon_e.v.sel == 3'b001)
                            chk("rt_funct7", {25'd0, instr[31:25]}, {25'd0, mon_e.v.f7});
                        else
                            chk("rt_imm", immgen(instr, mon_e.v.sel), mon_e.v.imm);
                    end
                    if (!mon_e.rnd && (mon_e.v.exp_ie || mon_e.v.exp_se) && exp_errcnt != 8'hFF)
                        exp_errcnt = exp_errcnt + 8'd1;
                end
            end
            if (addr_clr) exp_addr = BASE;
            else if (out_valid && out_ready) exp_addr = exp_addr + 32'd4;
        end
    end

    initial begin
        tbl[0]  = mk(3'b010, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5,        32'h0050_0093, 0, 0);
        tbl[1]  = mk(3'b100, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,        32'h0020_A423, 0, 0);
        tbl[2]  = mk(3'b101, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 0, 0);
        tbl[3]  = mk(3'b010, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h8000_0093, 1, 0);
        tbl[4]  = mk(3'b101, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,        32'h0000_0163, 1, 0);
        tbl[5]  = mk(3'b111, 7'b0110011, 5'd5, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,        32'h0000_0013, 0, 1);
        tbl[6]  = mk(3'b001, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 0, 0);
        tbl[7]  = mk(3'b001, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'd0,  32'h4020_81B3, 0, 0);
        tbl[8]  = mk(3'b011, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_2283, 0, 0);
        tbl[9]  = mk(3'b010, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 0, 0);
        tbl[10] = mk(3'b010, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2047,     32'h7FF0_0093, 0, 0);
        tbl[11] = mk(3'b010, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_F7FF, 32'h7FF0_0093, 1, 0);
        tbl[12] = mk(3'b101, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0FFE, 32'h7E00_0FE3, 0, 0);
        tbl[13] = mk(3'b101, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_F000, 32'h8000_0063, 0, 0);
        tbl[14] = mk(3'b101, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_1000, 32'h8000_0063, 1, 0);
        tbl[15] = mk(3'b100, 7'b0100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     32'h8000_0023, 1, 0);
        tbl[16] = mk(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0,        32'h0000_0013, 0, 1);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_clr = 1'b0;
        imm_sel = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm32 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_imm_err", {31'd0, imm_err}, 32'd0);
        chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_wr_addr", wr_addr, BASE);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: nothing after the accept edge, word visible after the next one
        drive(tbl[0], 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_s1_only", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // Remaining table back to back
        n_err = 0;
        for (int i = 0; i < NV; i++) if (tbl[i].exp_ie || tbl[i].exp_se) n_err++;
        for (int i = 1; i < NV; i++) drive(tbl[i], 1'b0);
        drain();
        chk("err_count_total", {24'd0, err_count}, n_err);

        // Backpressure: sink stalls while five words stream in
        out_ready = 1'b0;
        drive(tbl[6], 1'b0);
        drive(tbl[1], 1'b0);
        imm_sel = tbl[8].sel; opcode = tbl[8].op; rd = tbl[8].rd; rs1 = tbl[8].rs1; rs2 = tbl[8].rs2;
        funct3 = tbl[8].f3; funct7 = tbl[8].f7; imm32 = tbl[8].imm; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        held_instr = instr;
        chk("bp_head_word", held_instr, tbl[6].exp_instr);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_held_instr", instr, held_instr);
        chk("bp_still_blocked", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(tbl[8], 1'b0);
        drive(tbl[10], 1'b0);
        drive(tbl[2], 1'b0);
        drain();

        // Round trip through the reference immediate generator under random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] r;
            r = $urandom;
            rv.sel = 3'($urandom_range(1, 5));
            rv.op = 7'($urandom); rv.rd = 5'($urandom); rv.rs1 = 5'($urandom);
            rv.rs2 = 5'($urandom); rv.f3 = 3'($urandom); rv.f7 = 7'($urandom);
            case (rv.sel)
                3'b001:  rv.imm = r;
                3'b101:  rv.imm = {{19{r[12]}}, r[12:1], 1'b0};
                default: rv.imm = {{20{r[11]}}, r[11:0]};
            endcase
            rv.exp_instr = '0; rv.exp_ie = 1'b0; rv.exp_se = 1'b0;
            drive(rv, 1'b1);
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        // addr_clr on a handshake: current word keeps its address, next one restarts
        drive(tbl[0], 1'b0);
        drive(tbl[1], 1'b0);
        in_valid = 1'b0;
        addr_clr = 1'b1;
        @(posedge clk); #1;
        addr_clr = 1'b0;
        @(negedge clk);
        chk("clr_next_valid", {31'd0, out_valid}, 32'd1);
        chk("clr_next_addr", wr_addr, BASE);
        drain();

        // Reset with two words in flight
        drive(tbl[3], 1'b0);
        drive(tbl[4], 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_wr_addr", wr_addr, BASE);
        chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        sb_q.delete();
        exp_addr = BASE;
        exp_errcnt = 8'd0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        drive(tbl[0], 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Pipelined RV32I instruction encoder, the inverse of the immediate generator.
- Accepts decoded fields (opcode, registers, funct bits, 32-bit immediate, immediate-select code) and packs them into a 32-bit instruction word.
- Range-checks the immediate and streams encoded words with a byte address, for loading instruction memory (self-test program builder / boot loader path).
- Uses the same imm_sel encoding as the core's immediate generator, so a round trip through both blocks is lossless for legal immediates.

Parameters:
- ADDR_W, 32, width of the write-address counter.
- BASE_ADDR, 32'h0000_0000, address of the first emitted word; also the value reloaded on addr_clr.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- imm_sel  input  3  format: 001 R, 010 I-ALU, 011 I-load/JALR, 100 S, 101 B; all other values are illegal.
- opcode  input  7  instr[6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field, used for R only.
- imm32  input  32  immediate value, byte offset for B.
- addr_clr  input  1  synchronous reload of the address counter to BASE_ADDR.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  sink accepts the word.
- instr  output  32  encoded instruction.
- wr_addr  output  ADDR_W  byte address of instr.
- imm_err  output  1  immediate not representable in the selected format.
- sel_err  output  1  illegal imm_sel.
- err_count  output  ERRCNT_W  saturating count of emitted words with imm_err or sel_err set.

Behaviour:
- Reset: while rst_n is low, all stage valids, out_valid, instr, imm_err, sel_err and err_count are 0, and wr_addr is BASE_ADDR. Reset asserted mid-operation drops all in-flight words with no output.
- Pipeline:
  - Two stages. S1 registers the input bundle. S2 holds the packed word and error flags and drives the outputs.
  - Latency is 2 cycles from the in_valid&&in_ready edge to out_valid. Throughput is 1 word per cycle when out_ready is held high.
- Handshake:
  - s2_ready = !out_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready, driven combinationally.
  - Transfers occur only on valid&&ready. Outputs are held stable while out_valid && !out_ready.
  - Words are never dropped or duplicated.
- Packing, performed S1 -> S2:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I (010/011): {imm32[11:0], rs1, funct3, rd, opcode}.
  - S: {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode}.
  - B: {imm32[12], imm32[10:5], rs2, rs1, funct3, imm32[4:1], imm32[11], opcode}.
  - Illegal sel: instr = 32'h0000_0013 (NOP) and sel_err = 1.
- Range check:
  - I/S: imm_err = 1 unless imm32[31:11] is all-0 or all-1.
  - B: imm_err = 1 unless imm32[31:12] is all-0 or all-1 and imm32[0] = 0.
  - R and illegal sel: imm_err = 0.
  - On imm_err the word is still emitted with the truncated fields above.
- Address:
  - wr_addr tracks the S2 word. It advances by 4 on each out_valid&&out_ready and wraps modulo 2^ADDR_W.
  - addr_clr reloads BASE_ADDR and takes priority over a simultaneous advance.
  - The word presented in the same cycle as addr_clr keeps its old address; the next word gets BASE_ADDR.
- err_count: increments on the output handshake when (imm_err || sel_err), and saturates at all-ones.

Decomposition:
- Shared package: imm_sel codes (IMM_R=3'b001, IMM_I=3'b010, IMM_IL=3'b011, IMM_S=3'b100, IMM_B=3'b101) and NOP_INSTR = 32'h0000_0013, also used by the immediate generator.
- One natural sub-module: instr_pack, purely combinational; fields in -> instr, imm_err, sel_err out.

Test Plan:
- addi x1,x0,5 (sel 010, op 0010011, rd 1, rs1 0, f3 0, imm 5) -> instr 0x00500093, no errors, wr_addr BASE_ADDR, out_valid exactly 2 cycles after accept.
- sw x2,8(x1) (sel 100, op 0100011, f3 010, rs1 1, rs2 2, imm 8) -> 0x0020A423. beq x1,x2,-4 (sel 101, op 1100011, imm 0xFFFFFFFC) -> 0xFE208EE3, wr_addr advancing by 4 per word.
- Errors:
  - I imm 2048 with rd 1, op 0010011 -> instr 0x80000093 and imm_err = 1.
  - B imm 3 -> imm_err = 1.
  - sel 111 -> instr 0x00000013 and sel_err = 1.
  - err_count = 3 after these.
- Backpressure: in_valid held high with a stream of 5 words, out_ready low for 3 cycles -> in_ready drops after 2 accepts, outputs are held stable, all 5 words emerge in order with consecutive addresses.
- Round trip: 200 random legal bundles -> feeding instr and imm_sel into the immediate generator reproduces imm32 (B sign-extended 13-bit, S/I 12-bit).
- rst_n pulsed low with 2 words in flight -> out_valid falls immediately, wr_addr = BASE_ADDR, err_count = 0. addr_clr on a handshake cycle -> next word at BASE_ADDR.
